shift_seq: RTL and testbench

Command-level sequencer for the `shifter8` datapath. It accepts one shift command (data, direction, total amount 0–7) through a start/ready handshake. It then drives `shifter8` with a LOAD followed by as many 1–3-bit shift steps as needed, and returns the result with a one-cycle `done` pulse. It sits between the control logic that needs arbitrary 8-bit shifts and the `shifter8` instance, which it owns.

---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_seq_shifter8.sv | 25 ++
 rtl/shift_seq.sv | 126 ++++++++++++
 tb/tb_shift_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared FSM states, shifter8 op codes and command encodings for shift_seq.
package shift_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;
    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_LSR  = 3'b011;
    localparam logic [2:0] SH_ASR  = 3'b100;
    localparam logic [1:0] CMD_LSL  = 2'b00;
    localparam logic [1:0] CMD_LSR  = 2'b01;
    localparam logic [1:0] CMD_ASR  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;
    localparam int STEP_MAX_DEFAULT = 3;
    // Load-only commands never reach SHIFT, so their shifter code is irrelevant.
    function automatic logic [2:0] sh_code(input logic [1:0] op);
        return op == CMD_LSL ? SH_LSL : op == CMD_LSR ? SH_LSR : op == CMD_ASR ? SH_ASR : SH_NOP;
    endfunction
endpackage

// File: rtl/shift_seq_shifter8.sv
// shifter8: 8-bit register with load and 0-3 bit LSL/LSR/ASR per cycle.
module shifter8
    import shift_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] op,
    input  logic [1:0] shamt,
    input  logic [7:0] d_in,
    output logic [7:0] d_out
);
    logic [7:0] d_q, d_d;
    logic signed [7:0] asr;
    always_comb begin
        asr = $signed(d_q) >>> shamt;
        d_d = op == SH_LOAD ? d_in :
              op == SH_LSL  ? d_q << shamt :
              op == SH_LSR  ? d_q >> shamt :
              op == SH_ASR  ? asr : d_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) d_q <= 8'h00;
        else          d_q <= d_d;
    assign d_out = d_q;
endmodule

// File: rtl/shift_seq.sv
// shift_seq: sequences LOAD plus 1..STEP_MAX-bit steps on shifter8 per command;
// SHIFT_SEQ_PEND_EN adds a one-entry pending command slot.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_amt,
    input  logic [7:0] cmd_data,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] result
);
    localparam logic [2:0] STEP_L = 3'(STEP_MAX);
    state_e     state_q, state_d;
    logic [7:0] data_q, data_d, result_q, result_d, d_out;
    logic [2:0] op_q, op_d, rem_q, rem_d, step, sh_op;
    logic [2:0] cmd_rem, cmd_code, ld_op, ld_rem;
    logic [7:0] ld_data;
    logic [1:0] sh_shamt;
    logic       accept, direct, ld;
    assign cmd_rem  = cmd_op == CMD_LOAD ? 3'd0 : cmd_amt;
    assign cmd_code = sh_code(cmd_op);
    assign accept   = start && ready;
`ifdef SHIFT_SEQ_PEND_EN
    logic       pend_v_q, pend_v_d, drain, fill;
    logic [7:0] pend_data_q, pend_data_d;
    logic [2:0] pend_op_q, pend_op_d, pend_rem_q, pend_rem_d;
    assign ready   = state_q == ST_IDLE || !pend_v_q;
    assign drain   = pend_v_q && (state_q == ST_IDLE || state_q == ST_DONE);
    assign direct  = accept && state_q == ST_IDLE && !pend_v_q;
    assign fill    = accept && !direct;
    assign ld      = direct || drain;
    assign ld_data = drain ? pend_data_q : cmd_data;
    assign ld_op   = drain ? pend_op_q : cmd_code;
    assign ld_rem  = drain ? pend_rem_q : cmd_rem;
    always_comb begin
        pend_v_d    = fill ? 1'b1 : drain ? 1'b0 : pend_v_q;
        pend_data_d = fill ? cmd_data : pend_data_q;
        pend_op_d   = fill ? cmd_code : pend_op_q;
        pend_rem_d  = fill ? cmd_rem : pend_rem_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pend_v_q    <= 1'b0;
            pend_data_q <= 8'h00;
            pend_op_q   <= SH_NOP;
            pend_rem_q  <= 3'd0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_op_q   <= pend_op_d;
            pend_rem_q  <= pend_rem_d;
        end
`else
    assign ready   = state_q == ST_IDLE;
    assign direct  = accept;
    assign ld      = direct;
    assign ld_data = cmd_data;
    assign ld_op   = cmd_code;
    assign ld_rem  = cmd_rem;
`endif
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        op_d     = op_q;
        rem_d    = rem_q;
        result_d = result_q;
        sh_op    = SH_NOP;
        sh_shamt = 2'd0;
        step     = rem_q < STEP_L ? rem_q : STEP_L;
        if (ld) begin
            data_d = ld_data;
            op_d   = ld_op;
            rem_d  = ld_rem;
        end
        unique case (state_q)
            ST_IDLE:  state_d = ld ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                sh_op   = SH_LOAD;
                state_d = rem_q != 3'd0 ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                sh_op    = op_q;
                sh_shamt = step[1:0];
                rem_d    = rem_q - step;
                state_d  = rem_q == step ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                result_d = d_out;
                state_d  = ld ? ST_LOAD : ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            data_q   <= 8'h00;
            op_q     <= SH_NOP;
            rem_q    <= 3'd0;
            result_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    shifter8 u_shifter8 (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (sh_op),
        .shamt   (sh_shamt),
        .d_in    (data_q),
        .d_out   (d_out)
    );
    assign busy   = state_q != ST_IDLE;
    assign done   = state_q == ST_DONE;
    assign result = result_q;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and random commands against an arithmetic reference model of shift_seq.
module tb_shift_seq;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_amt = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       ready, busy, done;
    logic [7:0] result;
    int n_checks = 0;
    int n_fail = 0;

    shift_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .cmd_op   (cmd_op),
        .cmd_amt  (cmd_amt),
        .cmd_data (cmd_data),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [1:0] op, input logic [2:0] amt);
        logic [7:0] r;
        r = d;
        if (op != 2'b11)
            for (int i = 0; i < int'(amt); i++)
                r = op == 2'b00 ? {r[6:0], 1'b0} : op == 2'b01 ? {1'b0, r[7:1]} : {r[7], r[7:1]};
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [2:0] amt);
        return op == 2'b11 ? 2 : 2 + (int'(amt) + 2) / 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] d, input logic [1:0] op, input logic [2:0] amt);
        @(negedge clk);
        start = 1'b1; cmd_data = d; cmd_op = op; cmd_amt = amt;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] d, input logic [1:0] op, input logic [2:0] amt);
        int got;
        @(negedge clk);
        check({tag, "_ready"}, ready, 1);
        issue(d, op, amt);
        got = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) check({tag, "_busy"}, busy, 1);
            if (done) begin got = k; break; end
            @(posedge clk); #1;
        end
        check({tag, "_latency"}, got, ref_lat(op, amt));
        @(posedge clk); #1;
        check({tag, "_result"}, result, ref_res(d, op, amt));
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int done_at[$];
        logic [7:0] res_q[$];
        logic prev_done;
        int n_done;
        #12;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 8'h00);
        @(negedge clk) reset_n = 1'b1;

        run_cmd("lsl", 8'h77, 2'b00, 3'd1);
        check("lsl_plan", result, 8'hEE);
        run_cmd("lsr", 8'h80, 2'b01, 3'd7);
        check("lsr_plan", result, 8'h01);
        run_cmd("asr", 8'h80, 2'b10, 3'd5);
        check("asr_plan", result, 8'hFC);
        run_cmd("ldonly", 8'h5A, 2'b11, 3'd5);
        check("ldonly_plan", result, 8'h5A);
        run_cmd("amt0", 8'h5A, 2'b00, 3'd0);
        check("amt0_plan", result, 8'h5A);

        for (int i = 0; i < 24; i++)
            run_cmd("rand", 8'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));

        // second command arrives while the first is in SHIFT
        issue(8'h80, 2'b01, 3'd7);
        @(posedge clk); #1;
        issue(8'h03, 2'b00, 3'd2);
        prev_done = 1'b0;
        for (int k = 3; k <= 22; k++) begin
            if (prev_done) res_q.push_back(result);
            if (done) done_at.push_back(k);
            prev_done = done;
            @(posedge clk); #1;
        end
`ifdef SHIFT_SEQ_PEND_EN
        check("busy_ndone", done_at.size(), 2);
        check("busy_nres", res_q.size(), 2);
        if (done_at.size() >= 2) check("busy_gap_ok", (done_at[1] - done_at[0]) >= 3, 1);
        if (res_q.size() >= 2) check("busy_res2", res_q[1], ref_res(8'h03, 2'b00, 3'd2));
`else
        check("busy_ndone", done_at.size(), 1);
        check("busy_nres", res_q.size(), 1);
`endif
        if (done_at.size() >= 1) check("busy_lat1", done_at[0], ref_lat(2'b01, 3'd7));
        if (res_q.size() >= 1) check("busy_res1", res_q[0], 8'h01);

        issue(8'h80, 2'b01, 3'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #2;
        check("mid_busy", busy, 0);
        check("mid_ready", ready, 1);
        check("mid_result", result, 8'h00);
        check("mid_done", done, 0);
        @(negedge clk) reset_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid_no_done", n_done, 0);
        run_cmd("post_rst", 8'hC3, 2'b10, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
